mult_rr_arbiter: RTL

Two-requester round-robin arbiter that shares one combinational `multiplier` instance (N-bit operands, 2N-bit two's complement product) between two independent clients. Each client has a valid/ready request channel and a valid/ready response channel. The block registers the product and holds it until the owning client accepts it. It sits between the client blocks and the shared multiplier datapath, and is the only driver of the multiplier's A/B inputs.

---
 rtl/mult_pkg.sv | 13 +
 rtl/multiplier.sv | 18 +
 rtl/mult_rr_arbiter.sv | 76 +++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing for the round-robin multiplier arbiter.
// Holds the arbiter state encoding and default operand/product widths.
package mult_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int DEFAULT_N  = 4;
   localparam int DEFAULT_PW = 2 * DEFAULT_N;

endpackage

// File: rtl/multiplier.sv
// Combinational signed multiplier: N-bit two's complement operands, 2N-bit product.
module multiplier #(
   parameter int N = 4
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   logic [2*N-1:0] a_ext;
   logic [2*N-1:0] b_ext;

   // Sign-extend to full width so the low 2N bits of the product are exact.
   assign a_ext = {{N{a[N-1]}}, a};
   assign b_ext = {{N{b[N-1]}}, b};
   assign p     = a_ext * b_ext;

endmodule

// File: rtl/mult_rr_arbiter.sv
// Two-client round-robin arbiter sharing one multiplier; the product is registered
// and held until its owner accepts it, with accept and a new grant allowed on one edge.
module mult_rr_arbiter
   import mult_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [N-1:0]   a0,
   input  logic [N-1:0]   b0,
   input  logic [N-1:0]   a1,
   input  logic [N-1:0]   b1,
   output logic [1:0]     rsp_valid,
   input  logic [1:0]     rsp_ready,
   output logic [2*N-1:0] rsp_p,
   output logic           busy
);

   localparam int PW = 2 * N;

   state_t        state;
   logic          own;
   logic          last;
   logic          arb_en;
   logic          grant;
   logic          win;
   logic [N-1:0]  mult_a;
   logic [N-1:0]  mult_b;
   logic [PW-1:0] mult_p;

   // A held result blocks arbitration unless its owner is consuming it this cycle.
   assign arb_en = (state == IDLE) || rsp_ready[own];
   assign grant  = rst_n && arb_en && (req_valid != 2'b00);

   always_comb begin
      win = ~last;
      case (req_valid)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         default: win = ~last;
      endcase
   end

   assign req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign mult_a    = win ? a1 : a0;
   assign mult_b    = win ? b1 : b0;

   multiplier #(.N(N)) u_mult (
      .a (mult_a),
      .b (mult_b),
      .p (mult_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         own   <= 1'b0;
         last  <= 1'b1;
         rsp_p <= '0;
      end else if (grant) begin
         state <= HOLD;
         own   <= win;
         last  <= win;
         rsp_p <= mult_p;
      end else if (state == HOLD && rsp_ready[own]) begin
         state <= IDLE;
      end
   end

   assign busy      = (state == HOLD);
   assign rsp_valid = busy ? (own ? 2'b10 : 2'b01) : 2'b00;

endmodule
